chunked_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 15 +
 rtl/chunk_add.sv | 14 +
 rtl/chunked_adder.sv | 152 +++++++++++++++
 tb/tb_chunked_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Guarded so a bad CHUNK=0 still elaborates far enough to hit the config check.
  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
    return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module chunk_add #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per cycle with a rippled carry register,
// valid/ready on both sides, carry-out and signed-overflow flags.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NChunk = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam int unsigned BaseW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cin_q, cin_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [BaseW-1:0] base;
  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_cout;

  assign base    = BaseW'(32'(idx_q) * CHUNK);
  assign chunk_x = a_q[base +: CHUNK];
  assign chunk_y = b_q[base +: CHUNK];

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x    (chunk_x),
    .y    (chunk_y),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cin_d       = cin_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          cin_d      = carry_in;
          carry_d    = carry_in;
          sum_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        sum_d[base +: CHUNK] = chunk_s;
        carry_d              = chunk_cout;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Top chunk's MSB is the result sign bit.
          carry_out_d = chunk_cout;
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cin_q       <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cin_q       <= cin_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

  a_excl: assert property (@(posedge clk) !(in_ready && out_valid));

  a_hold: assert property (@(posedge clk)
    (!rst && out_valid && !out_ready) |=> (out_valid && $stable({carry_out, overflow, sum})));

  a_result: assert property (@(posedge clk)
    out_valid |-> ({carry_out, sum} == ({1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(cin_q))));

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: a 4-bit-chunk instance and a single-chunk instance.
module tb_chunked_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_edge;
  } exp_t;

  logic        clk, rst;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, ovf4;
  logic [15:0] a4, b4, sum4;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q4[$];
  exp_t q16[$];
  exp_t e4, e16;
  logic [17:0] held4  = '0;
  logic [17:0] held16 = '0;
  logic        ov4_prev  = 1'b0;
  logic        ov16_prev = 1'b0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .carry_in  (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .carry_out (cout4),
    .overflow  (ovf4)
  );

  chunked_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .carry_in  (cin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .carry_out (cout16),
    .overflow  (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input int acc);
    logic [16:0] full;
    exp_t        r;
    full       = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    r.sum      = full[15:0];
    r.cout     = full[16];
    r.ovf      = (a[15] == b[15]) && (full[15] != a[15]);
    r.acc_edge = acc;
    return r;
  endfunction

  // Monitors sample on the falling edge; cyc is the index of the latest rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      ov4_prev = 1'b0;
    end else begin
      check_eq("excl4", 32'(in_ready4 & out_valid4), 0);
      if (in_valid4 && in_ready4) q4.push_back(model(a4, b4, cin4, cyc + 1));
      if (out_valid4 && !ov4_prev) begin
        check_eq("out_expected4", 32'(q4.size() != 0), 1);
        if (q4.size() != 0) check_eq("latency4", cyc - q4[0].acc_edge, 4);
        held4 = {cout4, ovf4, sum4};
      end else if (out_valid4) begin
        check_eq("hold4", {cout4, ovf4, sum4}, held4);
      end
      if (out_valid4 && out_ready4 && q4.size() != 0) begin
        e4 = q4.pop_front();
        check_eq("sum4", sum4, e4.sum);
        check_eq("cout4", cout4, e4.cout);
        check_eq("ovf4", ovf4, e4.ovf);
      end
      ov4_prev = out_valid4;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      ov16_prev = 1'b0;
    end else begin
      check_eq("excl16", 32'(in_ready16 & out_valid16), 0);
      if (in_valid16 && in_ready16) q16.push_back(model(a16, b16, cin16, cyc + 1));
      if (out_valid16 && !ov16_prev) begin
        check_eq("out_expected16", 32'(q16.size() != 0), 1);
        if (q16.size() != 0) check_eq("latency16", cyc - q16[0].acc_edge, 1);
        held16 = {cout16, ovf16, sum16};
      end else if (out_valid16) begin
        check_eq("hold16", {cout16, ovf16, sum16}, held16);
      end
      if (out_valid16 && out_ready16 && q16.size() != 0) begin
        e16 = q16.pop_front();
        check_eq("sum16", sum16, e16.sum);
        check_eq("cout16", cout16, e16.cout);
        check_eq("ovf16", ovf16, e16.ovf);
      end
      ov16_prev = out_valid16;
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input bit wide, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    int n = 0;
    while (!(wide ? in_ready16 : in_ready4) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("send_ready", 32'(wide ? in_ready16 : in_ready4), 1);
    if (wide) begin
      a16 = a; b16 = b; cin16 = cin; in_valid16 = 1'b1;
    end else begin
      a4 = a; b4 = b; cin4 = cin; in_valid4 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid4  = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic drain(input bit wide);
    int n = 0;
    while ((wide ? q16.size() : q4.size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", wide ? q16.size() : q4.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready4, 1);
    check_eq("rst_out_valid", out_valid4, 0);
    check_eq("rst_sum", sum4, 0);
    check_eq("rst_cout", cout4, 0);
    check_eq("rst_ovf", ovf4, 0);
    check_eq("rst_in_ready16", in_ready16, 1);
    @(posedge clk);
    #1;

    send(0, 16'h00FF, 16'h0001, 1'b0); drain(0);
    send(0, 16'hFFFF, 16'h0001, 1'b0); drain(0);
    send(0, 16'h7FFF, 16'h0000, 1'b1); drain(0);
    send(0, 16'h8000, 16'hFFFF, 1'b1); drain(0);
    repeat (8) begin
      send(0, 16'($urandom), 16'($urandom), 1'($urandom)); drain(0);
    end

    // Backpressure with competing operands offered while the result is held.
    out_ready4 = 1'b0;
    send(0, 16'h1234, 16'h4321, 1'b1);
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid", out_valid4, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b0;
    end
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(negedge clk);
    check_eq("bp_in_ready", in_ready4, 1);
    check_eq("bp_out_valid", out_valid4, 0);
    check_eq("bp_one_consumed", q4.size(), 0);
    @(posedge clk);
    #1;

    // Reset after two BUSY cycles drops the operation.
    send(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", in_ready4, 1);
    check_eq("abort_out_valid", out_valid4, 0);
    check_eq("abort_sum", sum4, 0);
    repeat (8) begin
      @(negedge clk);
      check_eq("abort_quiet", out_valid4, 0);
    end
    @(posedge clk);
    #1;
    send(0, 16'h0F0F, 16'h00F1, 1'b0); drain(0);

    // Single-chunk instance.
    send(1, 16'h8000, 16'h8000, 1'b0); drain(1);
    send(1, 16'h7FFF, 16'h0001, 1'b0); drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
